// File: rtl/mux_scan_serializer_pkg.sv
// Shared types and defaults for the mux scan serializer.
// Holds the FSM encoding and the word geometry.
package mux_scan_serializer_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int SEL_W_DEF = 4;
  localparam int LAST_SEL  = WIDTH_DEF - 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_e;

endpackage

// File: rtl/mux_scan_serializer_mux.sv
// Purely combinational WIDTH:1 bit mux.
// sel=0 picks in[0], the leftmost bit of the vector.
module mux_16_1_comb
  import mux_scan_serializer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SEL_W = SEL_W_DEF
) (
  output logic             out,
  input  logic [0:WIDTH-1] in,
  input  logic [0:SEL_W-1] sel
);

  always_comb begin
    out = in[sel];
  end

endmodule

// File: rtl/mux_scan_serializer.sv
// Parallel-in, serial-out scan stage feeding the 16:1 mux path.
// Streams a captured word MSB-first over a valid/ready handshake.
module mux_scan_serializer
  import mux_scan_serializer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SEL_W = SEL_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [0:WIDTH-1] load_data,
  output logic             ser_out,
  output logic             ser_valid,
  input  logic             ser_ready,
  output logic             ser_last,
  output logic [0:SEL_W-1] sel,
  output logic             busy
);

  localparam logic [0:SEL_W-1] LastSel = SEL_W'(WIDTH - 1);
  localparam logic [0:SEL_W-1] SelOne  = SEL_W'(1);

  if (WIDTH != (1 << SEL_W)) begin : g_bad_geom
    $error("WIDTH must equal 2**SEL_W");
  end

  state_e             state_q, state_d;
  logic [0:WIDTH-1]   data_q, data_d;
  logic [0:SEL_W-1]   sel_q, sel_d;
  logic               ser_valid_q, ser_valid_d;
  logic               busy_q, busy_d;
  logic               is_last;
  logic               beat;
  logic               mux_bit;

  assign is_last = (sel_q == LastSel);
  assign beat    = ser_valid_q & ser_ready;

  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    sel_d       = sel_q;
    load_ready  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        load_ready = 1'b1;
        if (load_valid) begin
          data_d  = load_data;
          sel_d   = '0;
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        load_ready = is_last & ser_ready;
        if (beat) begin
          if (!is_last) begin
            sel_d = sel_q + SelOne;
          end else if (load_valid) begin
            // Back-to-back word: no idle bubble.
            data_d = load_data;
            sel_d  = '0;
          end else begin
            sel_d   = '0;
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        sel_d   = '0;
      end
    endcase
    ser_valid_d = (state_d == ST_SCAN);
    busy_d      = (state_d == ST_SCAN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      data_q      <= '0;
      sel_q       <= '0;
      ser_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      sel_q       <= sel_d;
      ser_valid_q <= ser_valid_d;
      busy_q      <= busy_d;
    end
  end

  mux_16_1_comb #(
    .WIDTH(WIDTH),
    .SEL_W(SEL_W)
  ) u_mux (
    .out(mux_bit),
    .in (data_q),
    .sel(sel_q)
  );

  assign ser_out   = mux_bit;
  assign ser_valid = ser_valid_q;
  assign ser_last  = ser_valid_q & is_last;
  assign sel       = sel_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mux_scan_serializer.sv
// Directed bench for mux_scan_serializer.
// Table vectors plus hand sequences for stall, chaining and reset.
module tb_mux_scan_serializer;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_valid;
  logic        load_ready;
  logic [0:15] load_data;
  logic        ser_out;
  logic        ser_valid;
  logic        ser_ready;
  logic        ser_last;
  logic [0:3]  sel;
  logic        busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mux_scan_serializer dut (
    .clk       (clk),
    .rst       (rst),
    .load_valid(load_valid),
    .load_ready(load_ready),
    .load_data (load_data),
    .ser_out   (ser_out),
    .ser_valid (ser_valid),
    .ser_ready (ser_ready),
    .ser_last  (ser_last),
    .sel       (sel),
    .busy      (busy)
  );

  typedef struct {
    logic [0:15] data;
    logic [0:15] stream;
    int          ones;
  } vec_t;

  vec_t tbl[4];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [0:15] w);
    load_data  = w;
    load_valid = 1'b1;
    chk("load_ready_idle", 32'(load_ready), 32'd1);
    tick();
    load_valid = 1'b0;
  endtask

  task automatic beat_chk(input string tag, input int i,
                          input logic b, input logic last);
    chk({tag, "_valid"}, 32'(ser_valid), 32'd1);
    chk({tag, "_sel"}, 32'(sel), 32'(i % 16));
    chk({tag, "_out"}, 32'(ser_out), 32'(b));
    chk({tag, "_last"}, 32'(ser_last), 32'(last));
  endtask

  task automatic run_stream(input string tag, input logic [0:15] exp,
                            output int ones, output int pos);
    ones = 0;
    pos  = -1;
    ser_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      beat_chk(tag, i, exp[i], i == 15);
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      if (ser_out === 1'b1) begin
        ones++;
        pos = int'(sel);
      end
      tick();
    end
    chk({tag, "_idle_valid"}, 32'(ser_valid), 32'd0);
    chk({tag, "_idle_ready"}, 32'(load_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ones;
    int pos;
    logic [0:15] w;
    logic [0:31] pair;

    tbl[0] = '{16'h8001, 16'b1000000000000001, 2};
    tbl[1] = '{16'h1234, 16'b0001001000110100, 5};
    tbl[2] = '{16'hC003, 16'b1100000000000011, 4};
    tbl[3] = '{16'h0000, 16'b0000000000000000, 0};

    rst        = 1'b1;
    load_valid = 1'b0;
    load_data  = '0;
    ser_ready  = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk("rst_load_ready", 32'(load_ready), 32'd1);
      chk("rst_ser_valid", 32'(ser_valid), 32'd0);
      chk("rst_sel", 32'(sel), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_last", 32'(ser_last), 32'd0);
      chk("rst_out", 32'(ser_out), 32'd0);
      tick();
    end

    for (int v = 0; v < 4; v++) begin
      load(tbl[v].data);
      run_stream("tbl", tbl[v].stream, ones, pos);
      chk("tbl_ones", 32'(ones), 32'(tbl[v].ones));
    end

    // Backpressure: stall three cycles on sel=2.
    load(16'h2000);
    w = 16'b0010000000000000;
    ser_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i == 2) begin
        ser_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          beat_chk("stall", 2, 1'b1, 1'b0);
          chk("stall_ready", 32'(load_ready), 32'd0);
          tick();
        end
        ser_ready = 1'b1;
      end
      beat_chk("bp", i, w[i], i == 15);
      tick();
    end
    chk("bp_idle", 32'(ser_valid), 32'd0);

    // Back-to-back words with load_valid held high.
    load(16'hA5A5);
    pair = 32'hA5A50F0F;
    load_data  = 16'h0F0F;
    load_valid = 1'b1;
    ser_ready  = 1'b1;
    for (int i = 0; i < 32; i++) begin
      if (i == 16) load_valid = 1'b0;
      beat_chk("b2b", i, pair[i], (i % 16) == 15);
      chk("b2b_ready", 32'(load_ready), 32'((i % 16) == 15));
      tick();
    end
    chk("b2b_idle", 32'(ser_valid), 32'd0);

    // Reset at beat 7 of an all-ones word.
    load(16'hFFFF);
    for (int i = 0; i < 6; i++) begin
      beat_chk("pre_rst", i, 1'b1, 1'b0);
      tick();
    end
    chk("pre_rst_sel", 32'(sel), 32'd6);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_valid", 32'(ser_valid), 32'd0);
    chk("mid_rst_ready", 32'(load_ready), 32'd1);
    chk("mid_rst_sel", 32'(sel), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_out", 32'(ser_out), 32'd0);
    load(16'h8000);
    run_stream("post_rst", 16'b1000000000000000, ones, pos);
    chk("post_rst_ones", 32'(ones), 32'd1);

    // One-hot walk.
    for (int k = 0; k < 16; k++) begin
      w = '0;
      w[k] = 1'b1;
      load(w);
      run_stream("onehot", w, ones, pos);
      chk("onehot_ones", 32'(ones), 32'd1);
      chk("onehot_pos", 32'(pos), 32'(k));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mux_scan_serializer.md
Name: mux_scan_serializer

Overview:
- Parallel-in, serial-out scan stage that sits directly upstream of the 16:1 mux data path.
- Captures a 16-bit word, then drives the 4-bit select from 0 to 15, one step per accepted beat.
- Emits the selected bit as a serial stream with a valid/ready handshake.
- Bit index 0 is the leftmost (MSB) bit of the [0:WIDTH-1] vector, so the stream is MSB-first.

Parameters:
- WIDTH, 16: number of input bits; must be a power of 2.
- SEL_W, 4: select width; must equal log2(WIDTH).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- load_valid  input  1  upstream word available
- load_ready  output  1  stage can capture a word this cycle
- load_data  input  [0:WIDTH-1]  parallel word; bit 0 is sent first
- ser_out  output  1  current serial bit, equal to data_reg[sel]
- ser_valid  output  1  ser_out is valid
- ser_ready  input  1  downstream accepts the current bit
- ser_last  output  1  current bit is bit WIDTH-1
- sel  output  [0:SEL_W-1]  current select index, exported for observation
- busy  output  1  a word is being scanned

Behaviour:
- Reset (sampled at posedge while rst=1):
  - state=IDLE, data_reg=0, sel=0.
  - ser_valid=0, ser_last=0, busy=0, load_ready=1.
  - ser_out=0, since data_reg=0.
- States: IDLE, SCAN.
- IDLE:
  - load_ready=1, ser_valid=0.
  - On load_valid&&load_ready: data_reg<=load_data, sel<=0, go to SCAN.
  - The first bit appears one cycle after capture.
- SCAN:
  - ser_valid=1, busy=1.
  - ser_out is combinational: data_reg[sel] through the mux sub-module.
  - ser_last=(sel==WIDTH-1).
- A beat transfers when ser_valid&&ser_ready.
- Transfer with sel<WIDTH-1: sel<=sel+1.
- Transfer with sel==WIDTH-1:
  - If load_valid=1, capture the new word: data_reg<=load_data, sel<=0, stay in SCAN. There is no bubble between words.
  - Otherwise, go to IDLE and sel<=0.
- load_ready = (state==IDLE) | (state==SCAN & sel==WIDTH-1 & ser_ready).
- Backpressure: while ser_ready=0 in SCAN, sel, data_reg, ser_out and ser_last hold stable. ser_valid stays 1 and is never withdrawn.
- load_valid in SCAN when load_ready=0: ignored, load_data not sampled.
- sel never wraps by increment; it only returns to 0 via load, end of word, or reset.
- Reset mid-scan aborts the word. On the next cycle ser_valid=0 and load_ready=1; no residual beats.
- Latency: capture edge to first valid bit is 1 cycle. One word takes WIDTH beats with ser_ready held high.
- All outputs except ser_out, ser_last and load_ready are registered. Those three are decoded from registered state; load_ready also depends combinationally on ser_ready.

Decomposition:
- Shared package holds:
  - state encoding constants: ST_IDLE=1'b0, ST_SCAN=1'b1;
  - WIDTH/SEL_W defaults;
  - localparam LAST_SEL=WIDTH-1.
- One natural sub-module: mux_16_1_comb, a purely combinational 16:1 mux.
  - Port order (out, in[0:15], sel[0:3]); sel=0 selects in[0].
  - Instantiated once, driven by data_reg and sel.
- FSM, counter and handshake logic stay in the top module.

Test Plan:
- Reset: rst=1 for 2 cycles, then 0 with load_valid=0 -> load_ready=1, ser_valid=0, sel=0, busy=0, held indefinitely.
- Single word: load_data=16'b1000000000000001, ser_ready=1 always:
  - 16 beats starting 1 cycle after capture.
  - ser_out=1,0(x14),1; sel steps 0..15.
  - ser_last=1 only on beat 16; IDLE on the following cycle.
- Backpressure: load 16'b0010000000000000, drop ser_ready for 3 cycles while sel=2 -> sel stays 2, ser_out=1, ser_valid=1 throughout. The scan resumes with sel=3 and ser_out=0, and completes 16 beats.
- Back-to-back: load 16'hA5A5, hold load_valid=1 with 16'h0F0F, ser_ready=1:
  - 32 consecutive valid beats, no bubble.
  - Beats 1-16 = 1010010110100101, beats 17-32 = 0000111100001111.
  - ser_last on beats 16 and 32.
- Reset mid-operation: assert rst at beat 7 of 16'hFFFF -> next cycle ser_valid=0, load_ready=1. A new load of 16'h8000 then starts at sel=0 with ser_out=1.
- One-hot walk: for k=0..15 load a one-hot word with bit k set -> exactly one beat per word has ser_out=1, at sel==k.
